// File: rtl/bcd_entry_pkg.sv
// bcd_entry_pkg: types, constants and helpers shared by the BCD operand entry
// block.
//   state_e  : controller states (EDIT, HOLD)
//   BCD_MAX  : largest legal BCD digit value
//   bcd_inc / bcd_dec : modulo-10 digit step helpers
package bcd_entry_pkg;

  typedef enum logic {
    EDIT = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Any out-of-range input also wraps to 0, so a digit can never settle on
  // a value from 10 to 15.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    logic [3:0] r;
    if (d >= BCD_MAX) r = 4'd0;
    else              r = d + 4'd1;
    return r;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    logic [3:0] r;
    if (d == 4'd0 || d > BCD_MAX) r = BCD_MAX;
    else                          r = d - 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_entry_if.sv
// bcd_entry_if: groups the pushbutton inputs, the consumer acknowledge and
// the operand outputs of bcd_entry.
//   master : button/ack driver and operand consumer (board or testbench)
//   slave  : bcd_entry itself
//   btn_inc/btn_dec/btn_sel/btn_ok : raw asynchronous pushbuttons, active-high
//   ack    : consumer acknowledge, synchronous to clk
//   aswu   : units digit, BCD
//   aswd   : tens digit, BCD
//   sel_d  : 0 = units selected, 1 = tens selected
//   valid  : operand pair committed and frozen
interface bcd_entry_if;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_sel;
  logic       btn_ok;
  logic       ack;
  logic [3:0] aswu;
  logic [3:0] aswd;
  logic       sel_d;
  logic       valid;

  modport master (
    output btn_inc, btn_dec, btn_sel, btn_ok, ack,
    input  aswu, aswd, sel_d, valid
  );

  modport slave (
    input  btn_inc, btn_dec, btn_sel, btn_ok, ack,
    output aswu, aswd, sel_d, valid
  );
endinterface

// File: rtl/bcd_entry_debouncer.sv
// debouncer: 2-flop synchronizer, stability counter and rising-edge press
// pulse for one raw pushbutton.
//   clk     : system clock
//   rst     : asynchronous reset, active-low
//   btn_raw : raw asynchronous button level, active-high
//   pulse   : one-cycle pulse per debounced 0->1 transition
// The debounced level follows the synchronized input only after DEB_CYCLES
// consecutive cycles of disagreement; any agreement clears the counter.
module debouncer #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam logic [DEB_W-1:0] CNT_TC  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] CNT_ONE = DEB_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_TC) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    // Registered so the pulse lines up with the cycle the level flips.
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/bcd_entry.sv
// bcd_entry: two-digit BCD operand entry from four pushbuttons.
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : bcd_entry_if.slave (buttons, ack, operand outputs)
//
// state | meaning
// ------+-------------------------------------------------------------
// EDIT  | digits editable with inc/dec, sel toggles digit, ok commits
// HOLD  | operands frozen, valid=1, waits for ack to return to EDIT
module bcd_entry
  import bcd_entry_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 19
) (
  input  logic              clk,
  input  logic              rst,
  bcd_entry_if.slave        bus
);

  logic inc_p, dec_p, sel_p, ok_p;

  debouncer #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_inc (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_inc), .pulse(inc_p));
  debouncer #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_dec (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_dec), .pulse(dec_p));
  debouncer #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_sel (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_sel), .pulse(sel_p));
  debouncer #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_ok (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_ok), .pulse(ok_p));

  state_e     state_q, state_d;
  logic [3:0] aswu_q, aswu_d;
  logic [3:0] aswd_q, aswd_d;
  logic       sel_digit_q, sel_digit_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d     = state_q;
    aswu_d      = aswu_q;
    aswd_d      = aswd_q;
    sel_digit_d = sel_digit_q;
    valid_d     = valid_q;
    case (state_q)
      EDIT: begin
        if (ok_p) begin
          // Commit wins; any coincident edit pulses are dropped.
          state_d = HOLD;
          valid_d = 1'b1;
        end else begin
          // inc and dec together cancel; edits use the pre-toggle selection.
          if (inc_p && !dec_p) begin
            if (sel_digit_q) aswd_d = bcd_inc(aswd_q);
            else             aswu_d = bcd_inc(aswu_q);
          end else if (dec_p && !inc_p) begin
            if (sel_digit_q) aswd_d = bcd_dec(aswd_q);
            else             aswu_d = bcd_dec(aswu_q);
          end
          if (sel_p) sel_digit_d = ~sel_digit_q;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          state_d     = EDIT;
          valid_d     = 1'b0;
          sel_digit_d = 1'b0;
        end
      end
      default: begin
        state_d = EDIT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EDIT;
      aswu_q      <= 4'd0;
      aswd_q      <= 4'd0;
      sel_digit_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      aswu_q      <= aswu_d;
      aswd_q      <= aswd_d;
      sel_digit_q <= sel_digit_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.aswu  = aswu_q;
  assign bus.aswd  = aswd_q;
  assign bus.sel_d = sel_digit_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_bcd_entry.sv
// tb_bcd_entry: randomized, self-checking bench for bcd_entry with a
// press-level reference model (DEB_CYCLES=4, DEB_W=3).
module tb_bcd_entry;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bcd_entry_if bus ();

  bcd_entry #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: operand digits, selected digit, committed flag.
  int m_u, m_d, m_sel, m_hold;

  function automatic logic [9:0] model_out();
    logic [3:0] u, d;
    u = 4'(m_u);
    d = 4'(m_d);
    return {u, d, m_sel[0], m_hold[0]};
  endfunction

  // mask = {ok, sel, dec, inc}, all pressed together.
  function automatic void model_press(input logic [3:0] mask);
    if (m_hold != 0) return;
    if (mask[3]) begin
      m_hold = 1;
      return;
    end
    if (mask[0] && !mask[1]) begin
      if (m_sel != 0) m_d = (m_d + 1) % 10;
      else            m_u = (m_u + 1) % 10;
    end else if (mask[1] && !mask[0]) begin
      if (m_sel != 0) m_d = (m_d + 9) % 10;
      else            m_u = (m_u + 9) % 10;
    end
    if (mask[2]) m_sel = 1 - m_sel;
  endfunction

  function automatic void model_ack();
    if (m_hold != 0) begin
      m_hold = 0;
      m_sel  = 0;
    end
  endfunction

  function automatic void model_reset();
    m_u = 0; m_d = 0; m_sel = 0; m_hold = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    {bus.btn_ok, bus.btn_sel, bus.btn_dec, bus.btn_inc} = mask;
    repeat (10) @(negedge clk);
    {bus.btn_ok, bus.btn_sel, bus.btn_dec, bus.btn_inc} = 4'b0000;
    repeat (10) @(negedge clk);
    model_press(mask);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    model_ack();
  endtask

  task automatic test_reset();
    logic [9:0] got;
    do_reset();
    got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
    vecs++;
    if (got !== 10'd0) begin
      errs++;
      $display("FAIL reset_state got=%h exp=%h", got, 10'd0);
    end
  endtask

  task automatic test_latency();
    logic [3:0] exp_u;
    @(negedge clk);
    bus.btn_inc = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_u = (k >= 7) ? 4'd1 : 4'd0;
      vecs++;
      if (bus.aswu !== exp_u || bus.aswd !== 4'd0 || bus.valid !== 1'b0) begin
        errs++;
        $display("FAIL latency cyc=%0d got aswu=%0d aswd=%0d valid=%b exp aswu=%0d aswd=0 valid=0",
                 k, bus.aswu, bus.aswd, bus.valid, exp_u);
      end
    end
    bus.btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    m_u = 1;
  endtask

  task automatic test_wrap();
    logic [9:0] got;
    for (int i = 0; i < 8; i++) press(4'b0001);
    got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
    vecs++;
    if (got !== model_out() || bus.aswu !== 4'd9) begin
      errs++;
      $display("FAIL wrap_to_9 got=%h exp=%h", got, model_out());
    end
    press(4'b0001);
    got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
    vecs++;
    if (got !== model_out() || bus.aswu !== 4'd0) begin
      errs++;
      $display("FAIL inc_9_to_0 got=%h exp=%h", got, model_out());
    end
    press(4'b0010);
    got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
    vecs++;
    if (got !== model_out() || bus.aswu !== 4'd9) begin
      errs++;
      $display("FAIL dec_0_to_9 got=%h exp=%h", got, model_out());
    end
  endtask

  task automatic test_bounce();
    logic [9:0] got;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.btn_inc = ~bus.btn_inc;
      @(negedge clk);
      got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
      vecs++;
      if (got !== model_out()) begin
        errs++;
        $display("FAIL bounce cyc=%0d got=%h exp=%h", i, got, model_out());
      end
    end
    bus.btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
    vecs++;
    if (got !== model_out()) begin
      errs++;
      $display("FAIL bounce_settle got=%h exp=%h", got, model_out());
    end
  endtask

  task automatic test_hold_ack();
    logic [9:0] got;
    do_reset();
    press(4'b0100);
    for (int i = 0; i < 3; i++) press(4'b0001);
    press(4'b1000);
    got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
    vecs++;
    if (got !== model_out() || got !== {4'd0, 4'd3, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL commit got=%h exp=%h", got, model_out());
    end
    press(4'b0001);
    got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
    vecs++;
    if (got !== model_out()) begin
      errs++;
      $display("FAIL hold_frozen got=%h exp=%h", got, model_out());
    end
    pulse_ack();
    got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
    vecs++;
    if (got !== model_out() || got !== {4'd0, 4'd3, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL ack_release got=%h exp=%h", got, model_out());
    end
  endtask

  task automatic test_reset_hold();
    logic [9:0] got;
    logic [3:0] exp_u;
    do_reset();
    for (int i = 0; i < 5; i++) press(4'b0001);
    press(4'b1000);
    got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
    vecs++;
    if (got !== model_out() || got !== {4'd5, 4'd0, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL hold_5 got=%h exp=%h", got, model_out());
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
    vecs++;
    if (got !== 10'd0) begin
      errs++;
      $display("FAIL async_reset got=%h exp=%h", got, 10'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    // Button pressed, reset mid-debounce while still held.
    @(negedge clk);
    bus.btn_inc = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_u = (k >= 7) ? 4'd1 : 4'd0;
      vecs++;
      if (bus.aswu !== exp_u || bus.valid !== 1'b0) begin
        errs++;
        $display("FAIL held_thru_reset cyc=%0d got aswu=%0d valid=%b exp aswu=%0d valid=0",
                 k, bus.aswu, bus.valid, exp_u);
      end
    end
    bus.btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    m_u = 1;
  endtask

  task automatic test_random();
    logic [9:0] got;
    logic [3:0] mask;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        pulse_ack();
        @(negedge clk);
      end else begin
        mask = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 3) != 0) mask[3] = 1'b0;
        if (mask == 4'b0000) mask = 4'b0001;
        press(mask);
      end
      got = {bus.aswu, bus.aswd, bus.sel_d, bus.valid};
      vecs++;
      if (got !== model_out()) begin
        errs++;
        $display("FAIL random op=%0d got=%h exp=%h", n, got, model_out());
      end
      if (bus.aswu > 4'd9 || bus.aswd > 4'd9) begin
        errs++;
        $display("FAIL bcd_range op=%0d got aswu=%0d aswd=%0d exp <=9", n, bus.aswu, bus.aswd);
      end
    end
  endtask

  initial begin
    bus.btn_inc = 1'b0;
    bus.btn_dec = 1'b0;
    bus.btn_sel = 1'b0;
    bus.btn_ok  = 1'b0;
    bus.ack     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_latency();
    test_wrap();
    test_bounce();
    test_hold_ack();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bcd_entry.md
BCD_ENTRY -- requirements
Module: bcd_entry

Interface
REQ-001 Parameter DEB_CYCLES, default 500000: clock cycles a raw button must stay stable before the debounced level changes.
REQ-002 Parameter DEB_W, default 19: debounce counter width, with 2**DEB_W > DEB_CYCLES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 btn_inc  input  1  raw, asynchronous pushbutton, active-high: increment the selected digit.
REQ-006 btn_dec  input  1  raw, asynchronous pushbutton, active-high: decrement the selected digit.
REQ-007 btn_sel  input  1  raw, asynchronous pushbutton, active-high: toggle the selected digit.
REQ-008 btn_ok  input  1  raw, asynchronous pushbutton, active-high: commit the operand pair.
REQ-009 ack  input  1  consumer acknowledge, synchronous to clk.
REQ-010 aswu  output  4  units operand, BCD 0-9.
REQ-011 aswd  output  4  tens operand, BCD 0-9.
REQ-012 sel_d  output  1  0 = aswu selected, 1 = aswd selected.
REQ-013 valid  output  1  operand pair committed and stable.

Function
REQ-014 Each raw button SHALL pass through a 2-flop synchronizer, then a debouncer.
- Debounced level changes only after DEB_CYCLES consecutive cycles of a stable synchronized value differing from the current level.
- Counter clears on any mismatch.
REQ-015 A debounced 0->1 transition SHALL produce exactly one single-cycle press pulse; holding a button SHALL NOT auto-repeat.
REQ-016 Press latency SHALL be 2 synchronizer cycles + DEB_CYCLES + 1 cycles from a stable raw edge to the pulse.
REQ-017 FSM states SHALL be EDIT and HOLD; reset state is EDIT.
REQ-018 In EDIT, an inc pulse SHALL increment the selected digit modulo 10 (9 -> 0); the other digit is unchanged and no carry occurs.
REQ-019 In EDIT, a dec pulse SHALL decrement the selected digit modulo 10 (0 -> 9).
REQ-020 In EDIT, simultaneous inc and dec pulses SHALL leave the digits unchanged.
REQ-021 In EDIT, a sel pulse SHALL toggle sel_d; a same-cycle inc or dec pulse applies to the digit selected before the toggle.
REQ-022 In EDIT, an ok pulse SHALL move the FSM to HOLD with valid=1 on the next cycle; any same-cycle inc/dec/sel pulse SHALL be discarded.
REQ-023 In HOLD, aswu, aswd and sel_d SHALL be frozen, and inc/dec/sel/ok pulses SHALL be ignored.
REQ-024 In HOLD, ack=1 SHALL move the FSM to EDIT with valid=0 on the next cycle.
- Digits are retained; sel_d is cleared to 0.
REQ-025 ack in EDIT SHALL be ignored.
REQ-026 aswu and aswd SHALL never hold values 10-15.

Reset
REQ-027 Asserting rst (low) SHALL immediately, asynchronously, set: aswu=0, aswd=0, sel_d=0, valid=0, FSM=EDIT, all synchronizer flops and debounced levels =0, all debounce counters =0.
REQ-028 Reset asserted during HOLD or mid-debounce SHALL abort the operation; no press pulse is generated from pre-reset history.
REQ-029 After deassertion, a button already held high SHALL produce one pulse, after the full debounce latency.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef (EDIT, HOLD) and the constant BCD_MAX=9.
REQ-031 One sub-module, debouncer, SHALL contain synchronizer + debounce counter + edge pulse, parameterized by DEB_CYCLES/DEB_W, and SHALL be instantiated four times.

Verification (DEB_CYCLES=4, DEB_W=3)
REQ-032 Reset, then btn_inc held 12 cycles -> aswu=1 exactly 7 cycles after the raw edge; aswd=0, valid=0.
REQ-033 From aswu=9: one inc press -> aswu=0, aswd unchanged. From aswu=0: one dec press -> aswu=9.
REQ-034 btn_inc toggled every 2 cycles for 20 cycles, then released -> no digit change.
REQ-035 sel press, then 3 inc presses, then ok press -> aswd=3, aswu=0, valid=1; a further inc press leaves aswd=3; ack pulse -> valid=0, sel_d=0, aswd=3.
REQ-036 rst asserted for 1 cycle during HOLD with aswu=5 -> aswu=0, valid=0 immediately, FSM=EDIT.
